// File: rtl/data_mem_arbiter.sv
// Arbiter sharing the single-port data memory between the core LDR/STR path (C) and a
// debug/loader port (D): one access per cycle, round-robin on contention, bounded debug bursts.
module data_mem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
);

  typedef enum logic [1:0] {IDLE, CORE, DBG} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;      // 1 when D owned the most recent granted cycle
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              rd_c_q, rd_c_d;
  logic              rd_d_q, rd_d_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_c, grant_d, burst_lock;

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    grant_c     = 1'b0;
    grant_d     = 1'b0;
    burst_lock  = (state_q == DBG) && d_req && (burst_cnt_q < MaxBurst);

    // Grants are suppressed while reset is held so nothing reaches the memory.
    if (rst) begin
      if (c_req && d_req) begin
        if (burst_lock || !last_d_q) grant_d = 1'b1;
        else                         grant_c = 1'b1;
      end else if (c_req) begin
        grant_c = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end

    state_d     = grant_c ? CORE : (grant_d ? DBG : IDLE);
    last_d_d    = grant_d ? 1'b1 : (grant_c ? 1'b0 : last_d_q);
    burst_cnt_d = grant_d ? (c_req ? burst_cnt_q + 4'd1 : burst_cnt_q) : 4'd0;
    rd_c_d      = grant_c && !c_we;
    rd_d_d      = grant_d && !d_we;

    mem_we      = (grant_c && c_we) || (grant_d && d_we);
    mem_addr    = '0;
    mem_wdata   = '0;
    if (grant_c) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (grant_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end

    // Read return goes only to the owner of the previous cycle; rdata holds otherwise.
    c_rvalid    = rd_c_q && rst;
    d_rvalid    = rd_d_q && rst;
    c_rdata     = c_rvalid ? mem_rdata : c_rdata_q;
    d_rdata     = d_rvalid ? mem_rdata : d_rdata_q;
    c_rdata_d   = c_rdata;
    d_rdata_d   = d_rdata;

    c_gnt       = grant_c;
    d_gnt       = grant_d;
    core_stall  = c_req && !grant_c;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      burst_cnt_q <= 4'd0;
      rd_c_q      <= 1'b0;
      rd_d_q      <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      burst_cnt_q <= burst_cnt_d;
      rd_c_q      <= rd_c_d;
      rd_d_q      <= rd_d_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule
